inst_fetch_unit: RTL and testbench

- Consumer of the program-counter value. It samples the current PC, runs a request/acknowledge read on instruction memory, and holds the fetched word for decode under a valid/ready handshake.
- Pulses PCEn once per accepted instruction so the PC register advances. Sits between the PC register and decode in the multi-cycle CPU.
- All state updates on the rising edge of Clk, which leaves the negedge-updated PC a half cycle to settle.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/inst_fetch_unit_if.sv | 33 +++
 rtl/fetch_timeout_ctr.sv | 26 ++
 rtl/inst_fetch_unit.sv | 124 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
package fetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus: PC input, instruction-memory request/ack, decode valid/ready.
// Handshakes: IMemReq/IMemAddr stay stable until a cycle with IMemAck=1; Inst/InstPC stay stable while InstValid=1 and InstReady=0, transfer on InstValid&&InstReady.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import fetch_pkg::*;

  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic              Flush;
  logic              IMemReq;
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemAck;
  logic [DATA_W-1:0] IMemData;
  logic [DATA_W-1:0] Inst;
  logic [ADDR_W-1:0] InstPC;
  logic              InstValid;
  logic              InstReady;
  logic              PCEn;
  logic              Fault;
  fetch_state_e      State;

  modport master (
    input  Run, PC, Flush, IMemAck, IMemData, InstReady,
    output IMemReq, IMemAddr, Inst, InstPC, InstValid, PCEn, Fault, State
  );

  modport slave (
    output Run, PC, Flush, IMemAck, IMemData, InstReady,
    input  IMemReq, IMemAddr, Inst, InstPC, InstValid, PCEn, Fault, State
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for an instruction-memory ack; o_tc flags the
// cycle in which the wait reaches TIMEOUT_CYCLES. Used only with FETCH_TIMEOUT_EN.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Fires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign o_tc = i_inc && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: samples PC, reads instruction memory with req/ack,
// holds the word for decode and pulses PCEn on acceptance. Macro: FETCH_TIMEOUT_EN.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W         = ADDR_W_DEF,
  parameter int                DATA_W         = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_INST       = DATA_W'(NOP_INST_DEF),
  parameter int                TIMEOUT_CYCLES = 16
) (
  input logic           Clk,
  input logic           Clr,
  inst_fetch_unit_if.master bus
);

  fetch_state_e      r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_valid;
  logic              r_pcen;
  logic              r_fault;

  logic w_start;
  logic w_waiting;
  logic w_timeout;

  assign w_start   = (r_state == IDLE) && bus.Run && !bus.Flush && !r_fault;
  assign w_waiting = ((r_state == REQ) || (r_state == DRAIN)) && !bus.IMemAck;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (Clk),
    .i_rst   (Clr),
    .i_clear (w_start),
    .i_inc   (w_waiting),
    .o_tc    (w_timeout)
  );
`else
  // No counter: waits on the ack are unbounded and Fault never sets.
  assign w_timeout = 1'b0 & w_waiting & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_inst    <= NOP_INST;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
      r_pcen    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_pcen <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_addr  <= bus.PC & ~(ADDR_W'(3));
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_timeout) begin
            r_fault <= 1'b1;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (bus.IMemAck) begin
            r_req <= 1'b0;
            if (bus.Flush) begin
              r_state <= IDLE;
            end else begin
              r_inst    <= bus.IMemData;
              r_inst_pc <= r_addr;
              r_valid   <= 1'b1;
              r_state   <= HOLD;
            end
          end else if (bus.Flush) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // The outstanding read must complete before the bus can be reused.
          if (w_timeout) begin
            r_fault <= 1'b1;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (bus.IMemAck) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        HOLD: begin
          if (bus.Flush) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_state <= IDLE;
          end else if (bus.InstReady) begin
            r_pcen  <= 1'b1;
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.IMemReq   = r_req;
  assign bus.IMemAddr  = r_addr;
  assign bus.Inst      = r_inst;
  assign bus.InstPC    = r_inst_pc;
  assign bus.InstValid = r_valid;
  assign bus.PCEn      = r_pcen;
  assign bus.Fault     = r_fault;
  assign bus.State     = r_state;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and randomized bench for inst_fetch_unit with a transaction-level model.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic Clk;
  logic Clr;

  inst_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  inst_fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .NOP_INST(NOP), .TIMEOUT_CYCLES(4)
  ) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks;
  int failures;
  int exp_pcen;
  int pcen_seen;
  int pcen_b2b;
  logic prev_pcen;
  logic [DW-1:0] exp_q[$];

  initial begin
    pcen_seen = 0;
    pcen_b2b  = 0;
    prev_pcen = 1'b0;
  end

  always @(posedge Clk) begin
    if (bus.PCEn) pcen_seen <= pcen_seen + 1;
    if (bus.PCEn && prev_pcen) pcen_b2b <= pcen_b2b + 1;
    prev_pcen <= bus.PCEn;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Run       = 1'b0;
    bus.Flush     = 1'b0;
    bus.IMemAck   = 1'b0;
    bus.InstReady = 1'b0;
    bus.IMemData  = $urandom;
  endtask

  // One complete fetch: request, wait_n ack-less cycles, hold bp_n cycles, accept.
  task automatic fetch_txn(input logic [31:0] pc, input int wait_n,
                           input logic [31:0] data, input int bp_n);
    logic [31:0] a;
    logic [31:0] got;
    a = pc & 32'hFFFF_FFFC;
    bus.Run = 1'b1;
    bus.PC  = pc;
    tick();
    bus.Run = 1'b0;
    bus.PC  = $urandom;
    chk("req_raise", bus.IMemReq, 1'b1);
    chk("req_addr", bus.IMemAddr, a);
    for (int i = 0; i < wait_n; i++) begin
      tick();
      chk("wait_req", bus.IMemReq, 1'b1);
      chk("wait_addr", bus.IMemAddr, a);
      chk("wait_valid", bus.InstValid, 1'b0);
    end
    bus.IMemAck  = 1'b1;
    bus.IMemData = data;
    exp_q.push_back(data);
    tick();
    bus.IMemAck  = 1'b0;
    bus.IMemData = $urandom;
    got = exp_q.pop_front();
    chk("hold_valid", bus.InstValid, 1'b1);
    chk("hold_inst", bus.Inst, got);
    chk("hold_pc", bus.InstPC, a);
    chk("hold_req", bus.IMemReq, 1'b0);
    for (int i = 0; i < bp_n; i++) begin
      tick();
      chk("bp_valid", bus.InstValid, 1'b1);
      chk("bp_inst", bus.Inst, got);
      chk("bp_pcen", bus.PCEn, 1'b0);
    end
    bus.InstReady = 1'b1;
    tick();
    bus.InstReady = 1'b0;
    exp_pcen++;
    chk("acc_valid", bus.InstValid, 1'b0);
    chk("acc_inst", bus.Inst, NOP);
    chk("acc_pcen", bus.PCEn, 1'b1);
    tick();
    chk("post_pcen", bus.PCEn, 1'b0);
    chk("post_state", bus.State, IDLE);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_pcen = 0;
    bus.PC   = '0;
    idle_inputs();

    // reset with busy inputs: Clr must override them
    Clr = 1'b1;
    bus.Run = 1'b1;
    bus.IMemAck = 1'b1;
    tick();
    tick();
    chk("rst_req", bus.IMemReq, 1'b0);
    chk("rst_addr", bus.IMemAddr, 32'h0);
    chk("rst_inst", bus.Inst, NOP);
    chk("rst_instpc", bus.InstPC, 32'h0);
    chk("rst_valid", bus.InstValid, 1'b0);
    chk("rst_pcen", bus.PCEn, 1'b0);
    chk("rst_fault", bus.Fault, 1'b0);
    chk("rst_state", bus.State, IDLE);
    Clr = 1'b0;
    idle_inputs();
    tick();

    // basic zero-wait fetch
    fetch_txn(32'h0000_0010, 0, 32'h2008_0005, 0);
    // wait states and backpressure
    fetch_txn(32'h0000_0044, 3, 32'h1234_5678, 4);
    // unaligned PC
    fetch_txn(32'h0000_0013, 1, 32'hCAFE_0013, 1);

    // Run with Flush in IDLE starts nothing
    bus.Run = 1'b1;
    bus.Flush = 1'b1;
    bus.PC = 32'h80;
    tick();
    idle_inputs();
    chk("idle_flush_req", bus.IMemReq, 1'b0);
    chk("idle_flush_state", bus.State, IDLE);

    // Flush in REQ, ack arrives later in DRAIN
    bus.Run = 1'b1;
    bus.PC  = 32'h0000_0100;
    tick();
    bus.Run = 1'b0;
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    chk("drain_state", bus.State, DRAIN);
    chk("drain_req", bus.IMemReq, 1'b1);
    chk("drain_addr", bus.IMemAddr, 32'h100);
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    chk("drain_state2", bus.State, DRAIN);
    chk("drain_req2", bus.IMemReq, 1'b1);
    chk("drain_valid", bus.InstValid, 1'b0);
    bus.IMemAck = 1'b1;
    bus.IMemData = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    chk("drain_done_state", bus.State, IDLE);
    chk("drain_done_req", bus.IMemReq, 1'b0);
    chk("drain_done_valid", bus.InstValid, 1'b0);
    chk("drain_done_pcen", bus.PCEn, 1'b0);
    fetch_txn(32'h0000_0200, 0, 32'h0000_0AAA, 0);

    // Flush together with Ack in REQ
    bus.Run = 1'b1;
    bus.PC  = 32'h0000_0300;
    tick();
    bus.Run = 1'b0;
    bus.Flush = 1'b1;
    bus.IMemAck = 1'b1;
    bus.IMemData = 32'h5555_5555;
    tick();
    idle_inputs();
    chk("fa_state", bus.State, IDLE);
    chk("fa_req", bus.IMemReq, 1'b0);
    chk("fa_valid", bus.InstValid, 1'b0);

    // Flush together with InstReady in HOLD
    bus.Run = 1'b1;
    bus.PC  = 32'h0000_0400;
    tick();
    bus.Run = 1'b0;
    bus.IMemAck = 1'b1;
    bus.IMemData = 32'h7777_0000;
    tick();
    bus.IMemAck = 1'b0;
    chk("fh_hold", bus.InstValid, 1'b1);
    bus.Flush = 1'b1;
    bus.InstReady = 1'b1;
    tick();
    idle_inputs();
    chk("fh_valid", bus.InstValid, 1'b0);
    chk("fh_pcen", bus.PCEn, 1'b0);
    chk("fh_state", bus.State, IDLE);
    tick();
    chk("fh_pcen2", bus.PCEn, 1'b0);

    // Clr in REQ, then a late ack is ignored
    bus.Run = 1'b1;
    bus.PC  = 32'h0000_0500;
    tick();
    bus.Run = 1'b0;
    chk("mr_req", bus.IMemReq, 1'b1);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    chk("mr_req0", bus.IMemReq, 1'b0);
    chk("mr_state", bus.State, IDLE);
    bus.IMemAck = 1'b1;
    bus.IMemData = 32'hBAD0_BAD0;
    tick();
    idle_inputs();
    chk("late_ack_valid", bus.InstValid, 1'b0);
    chk("late_ack_state", bus.State, IDLE);

`ifdef FETCH_TIMEOUT_EN
    // no ack: Fault after 4 REQ cycles, then no new fetch until Clr
    bus.Run = 1'b1;
    bus.PC  = 32'h0000_0600;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_fault", bus.Fault, 1'b0);
    end
    tick();
    chk("to_fault", bus.Fault, 1'b1);
    chk("to_req", bus.IMemReq, 1'b0);
    tick();
    tick();
    chk("to_no_restart", bus.IMemReq, 1'b0);
    chk("to_sticky", bus.Fault, 1'b1);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    idle_inputs();
    chk("to_clr", bus.Fault, 1'b0);
    tick();
`else
    // long wait without ack: request persists and Fault stays low
    bus.Run = 1'b1;
    bus.PC  = 32'h0000_0600;
    tick();
    bus.Run = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("nto_fault", bus.Fault, 1'b0);
    chk("nto_req", bus.IMemReq, 1'b1);
    bus.Flush = 1'b1;
    bus.IMemAck = 1'b1;
    tick();
    idle_inputs();
    chk("nto_state", bus.State, IDLE);
`endif

    // randomized fetches
    for (int n = 0; n < 10; n++) begin
      fetch_txn($urandom, $urandom_range(0, 3), $urandom, $urandom_range(0, 3));
    end

    tick();
    chk("pcen_count", pcen_seen, exp_pcen);
    chk("pcen_b2b", pcen_b2b, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("final_fault", bus.Fault, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
